// File: rtl/gpio_input_debouncer.sv
// Per-bit synchroniser plus debounce filter for switch/button pins.
// Each bit updates its level only after the synchronised value has disagreed with it for STABLE_CYCLES cycles in a row.
//
//   state   | meaning
//   IDLE    | synchronised input equals dout; counter held at 0
//   QUALIFY | synchronised input differs from dout; counter runs toward STABLE_CYCLES-1
module gpio_input_debouncer #(
  parameter int WIDTH         = 2,
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 1000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             any_event
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);

  typedef enum logic {IDLE, QUALIFY} state_t;

  logic [SYNC_STAGES-1:0] sync_q [WIDTH];
  logic [CW-1:0]          cnt_q  [WIDTH];
  logic [WIDTH-1:0]       s;
  logic [WIDTH-1:0]       done;
  state_t                 mode   [WIDTH];

  always_comb begin
    s    = '0;
    done = '0;
    for (int i = 0; i < WIDTH; i++) begin
      s[i]    = sync_q[i][SYNC_STAGES-1];
      mode[i] = (s[i] != dout[i]) ? QUALIFY : IDLE;
      done[i] = (mode[i] == QUALIFY) && (cnt_q[i] == LAST);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < WIDTH; i++) begin
        sync_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
      dout      <= '0;
      rise      <= '0;
      fall      <= '0;
      any_event <= 1'b0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], din[i]};
        case (mode[i])
          IDLE: cnt_q[i] <= '0;
          QUALIFY: begin
            // Counter stops at LAST and clears on the update, so it cannot wrap.
            if (done[i]) begin
              dout[i]  <= s[i];
              cnt_q[i] <= '0;
            end else begin
              cnt_q[i] <= cnt_q[i] + 1'b1;
            end
          end
          default: cnt_q[i] <= '0;
        endcase
      end
      rise      <= done & s;
      fall      <= done & ~s;
      any_event <= |done;
    end
  end

endmodule

// File: tb/tb_gpio_input_debouncer.sv
// Directed bench for gpio_input_debouncer; an every-cycle reference model plus literal latency checks.
module tb_gpio_input_debouncer;

  localparam int W = 2;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] din = '0;
  logic [W-1:0] dout, rise, fall;
  logic         any_event;

  int n_checks = 0;
  int n_fail   = 0;
  bit check_en = 1'b0;
  int rise0_cnt = 0;
  int pulse_cnt = 0;

  gpio_input_debouncer #(.WIDTH(W), .SYNC_STAGES(2), .STABLE_CYCLES(N)) dut (
    .clk(clk), .rst(rst), .din(din), .dout(dout),
    .rise(rise), .fall(fall), .any_event(any_event)
  );

  always #5 clk = ~clk;

  // Reference: the value the filter sees is din delayed by two samples;
  // a bit flips once that value has disagreed with the level for N edges running.
  logic [W-1:0] sq [$];
  logic [W-1:0] m_dout, m_rise, m_fall;
  logic         m_any;
  int           run_start [W];
  int           edge_n = 0;

  always @(posedge clk) begin
    logic [W-1:0] sv;
    edge_n++;
    if (rst) begin
      sq.delete();
      sq.push_back('0);
      sq.push_back('0);
      m_dout = '0; m_rise = '0; m_fall = '0; m_any = 1'b0;
      for (int b = 0; b < W; b++) run_start[b] = -1;
    end else begin
      sv = sq.pop_front();
      sq.push_back(din);
      m_rise = '0; m_fall = '0;
      for (int b = 0; b < W; b++) begin
        if (sv[b] != m_dout[b]) begin
          if (run_start[b] < 0) run_start[b] = edge_n;
          if (edge_n - run_start[b] + 1 >= N) begin
            m_dout[b] = sv[b];
            if (sv[b]) m_rise[b] = 1'b1; else m_fall[b] = 1'b1;
            run_start[b] = -1;
          end
        end else begin
          run_start[b] = -1;
        end
      end
      m_any = |(m_rise | m_fall);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      chk("model_dout", 32'(dout), 32'(m_dout));
      chk("model_rise", 32'(rise), 32'(m_rise));
      chk("model_fall", 32'(fall), 32'(m_fall));
      chk("model_any",  32'(any_event), 32'(m_any));
      chk("rise_and_fall", 32'(rise & fall), 32'd0);
      if (rise[0] === 1'b1) rise0_cnt++;
      if (|(rise | fall)) pulse_cnt++;
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    // 1: reset then quiet input
    step(3);
    rst = 1'b0;
    check_en = 1'b1;
    step(50);
    chk("s1_dout", 32'(dout), 32'd0);
    chk("s1_no_pulses", 32'(pulse_cnt), 32'd0);

    // 3: three-cycle glitch on bit 0 never qualifies
    din = 2'b01;
    step(3);
    din = 2'b00;
    step(10);
    chk("s3_dout", 32'(dout), 32'd0);
    chk("s3_no_pulses", 32'(pulse_cnt), 32'd0);

    // 2: clean 0->1 on bit 0, dout valid after edge 6
    din = 2'b01;
    step(5);
    chk("s2_dout_edge5", 32'(dout), 32'd0);
    step(1);
    chk("s2_dout_edge6", 32'(dout), 32'b01);
    chk("s2_rise_edge6", 32'(rise), 32'b01);
    chk("s2_fall_edge6", 32'(fall), 32'b00);
    step(1);
    chk("s2_rise_edge7", 32'(rise), 32'b00);
    step(5);

    // 5: both bits change in one step
    din = 2'b10;
    step(6);
    chk("s5_dout", 32'(dout), 32'b10);
    chk("s5_fall", 32'(fall), 32'b01);
    chk("s5_rise", 32'(rise), 32'b10);
    chk("s5_any",  32'(any_event), 32'd1);
    step(1);
    chk("s5_any_after", 32'(any_event), 32'd0);
    step(5);

    // 4: bit 0 chatters every 2 cycles, then settles high
    rise0_cnt = 0;
    for (int k = 0; k < 10; k++) begin
      din = {1'b1, ~k[0]};
      step(2);
    end
    din = 2'b11;
    step(5);
    chk("s4_dout0_edge5", 32'(dout[0]), 32'd0);
    chk("s4_no_early_rise", 32'(rise0_cnt), 32'd0);
    step(1);
    chk("s4_dout_edge6", 32'(dout), 32'b11);
    chk("s4_rise_edge6", 32'(rise), 32'b01);
    step(10);
    chk("s4_single_rise", 32'(rise0_cnt), 32'd1);

    // 6: reset in the middle of qualification
    din = 2'b00;
    step(10);
    chk("s6_pre_dout", 32'(dout), 32'd0);
    din = 2'b11;
    step(4);
    rst = 1'b1;
    step(1);
    chk("s6_rst_dout", 32'(dout), 32'd0);
    chk("s6_rst_rise", 32'(rise), 32'd0);
    rst = 1'b0;
    step(5);
    chk("s6_dout_edge5", 32'(dout), 32'd0);
    step(1);
    chk("s6_dout_edge6", 32'(dout), 32'b11);
    chk("s6_rise_edge6", 32'(rise), 32'b11);
    chk("s6_any_edge6",  32'(any_event), 32'd1);
    step(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
